// File: rtl/johnson_pkg.sv
// Shared types and helpers for Johnson-code consumers.
package johnson_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } johnson_state_e;

    // Bits needed to hold a phase index of a 2N-long Johnson sequence.
    function automatic int idx_width(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/johnson_idx_decode.sv
// Combinational Johnson code -> {legal, phase index} decoder.
module johnson_idx_decode
    import johnson_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  code_i,
    output logic          legal_o,
    output logic [IW-1:0] idx_o
);

    int trans;
    int pop;

    // A Johnson code is a run of ones and a run of zeros, so it has at most
    // one transition between adjacent bits.
    always_comb begin
        trans = 0;
        pop   = 0;
        for (int i = 0; i < N; i++) begin
            pop = pop + int'(code_i[i]);
        end
        for (int i = 1; i < N; i++) begin
            if (code_i[i] != code_i[i-1]) begin
                trans = trans + 1;
            end
        end
        legal_o = (trans <= 1);
        if (code_i == '0) begin
            idx_o = '0;
        end else if (code_i[N-1]) begin
            idx_o = IW'(pop);
        end else begin
            idx_o = IW'(2 * N - pop);
        end
    end

endmodule

// File: rtl/johnson_seq_monitor.sv
// Johnson sequence monitor: decodes samples, tracks sequence lock and counts errors.
module johnson_seq_monitor
    import johnson_pkg::*;
#(
    parameter int N         = 4,
    parameter int LOCK_CNT  = 3,
    parameter int ERR_CNT_W = 8,
    localparam int IW = idx_width(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         code_in,
    input  logic                 code_vld,
    input  logic                 err_clr,
    output logic [IW-1:0]        idx,
    output logic                 idx_vld,
    output logic                 illegal,
    output logic                 seq_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int RW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

    johnson_state_e       state_q, state_d;
    logic [IW-1:0]        ref_q, ref_d;
    logic [RW-1:0]        run_q, run_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 idx_vld_q, idx_vld_d;
    logic                 illegal_q, illegal_d;
    logic                 seq_err_q, seq_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic          dec_legal;
    logic [IW-1:0] dec_idx;
    logic [IW-1:0] succ_idx;
    logic          is_succ;
    logic [ERR_CNT_W-1:0] err_base;

    johnson_idx_decode #(.N(N)) u_decode (
        .code_i  (code_in),
        .legal_o (dec_legal),
        .idx_o   (dec_idx)
    );

    // Sequence length 2N need not be a power of two, so wrap explicitly.
    assign succ_idx = (ref_q == IW'(2 * N - 1)) ? '0 : ref_q + IW'(1);
    assign is_succ  = (dec_idx == succ_idx);

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        run_d     = run_q;
        idx_d     = idx_q;
        idx_vld_d = 1'b0;
        illegal_d = 1'b0;
        seq_err_d = 1'b0;
        if (code_vld) begin
            if (!dec_legal) begin
                illegal_d = 1'b1;
                state_d   = HUNT;
                run_d     = '0;
            end else begin
                idx_d     = dec_idx;
                idx_vld_d = 1'b1;
                ref_d     = dec_idx;
                case (state_q)
                    HUNT: begin
                        run_d   = '0;
                        state_d = ACQ;
                    end
                    ACQ: begin
                        if (is_succ) begin
                            run_d = run_q + RW'(1);
                            if (run_q == RW'(LOCK_CNT - 1)) begin
                                state_d = LOCK;
                            end
                        end else begin
                            seq_err_d = 1'b1;
                            run_d     = '0;
                        end
                    end
                    LOCK: begin
                        if (!is_succ) begin
                            seq_err_d = 1'b1;
                            run_d     = '0;
                            state_d   = ACQ;
                        end
                    end
                    default: begin
                        state_d = HUNT;
                        run_d   = '0;
                    end
                endcase
            end
        end
    end

    // Clear takes effect first, so a clear coinciding with an error leaves 1.
    always_comb begin
        err_base  = err_clr ? '0 : err_cnt_q;
        err_cnt_d = err_base;
        if ((illegal_d || seq_err_d) && (err_base != '1)) begin
            err_cnt_d = err_base + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HUNT;
            ref_q     <= '0;
            run_q     <= '0;
            idx_q     <= '0;
            idx_vld_q <= 1'b0;
            illegal_q <= 1'b0;
            seq_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            run_q     <= run_d;
            idx_q     <= idx_d;
            idx_vld_q <= idx_vld_d;
            illegal_q <= illegal_d;
            seq_err_q <= seq_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign idx     = idx_q;
    assign idx_vld = idx_vld_q;
    assign illegal = illegal_q;
    assign seq_err = seq_err_q;
    assign locked  = (state_q == LOCK);
    assign err_cnt = err_cnt_q;

endmodule

// File: doc/johnson_seq_monitor.md
# johnson_seq_monitor

Receive-side companion to a twisted-ring (Johnson) counter. Samples an N-bit Johnson code each qualified cycle, decodes it to a binary phase index, and flags illegal codes and out-of-sequence steps. Runs a lock state machine and keeps a saturating error count. Sits downstream of any Johnson-sequence generator as a decoder and health checker.

## Interface
- N, default 4: code width; sequence length is 2N.
- LOCK_CNT, default 3: consecutive correct steps required to enter LOCK (≥1).
- ERR_CNT_W, default 8: width of error counter.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- code_in  in  N  Johnson code; bit N-1 is the first stage (fill enters at MSB).
- code_vld  in  1  code_in sampled this cycle.
- err_clr  in  1  synchronous clear of err_cnt.
- idx  out  $clog2(2N)  decoded phase index of last legal sample.
- idx_vld  out  1  one-cycle pulse: idx updated from a legal sample.
- illegal  out  1  one-cycle pulse: sampled code not a Johnson code.
- seq_err  out  1  one-cycle pulse: legal code but not successor of reference (ACQ/LOCK only).
- locked  out  1  state == LOCK.
- err_cnt  out  ERR_CNT_W  saturating count of illegal + seq_err pulses.

## Operation
- Legal codes (2N of 2^N): 1^k 0^(N-k), k=0..N, index k; 0^m 1^(N-m), m=1..N-1, index N+m.
- Decode: code==0 → 0; MSB==1 → popcount; else 2N − popcount. Example N=4: 0000→0, 1000→1, 1111→4, 0111→5, 0001→7.
- Successor rule: expected = (ref+1) mod 2N; 2N−1 → 0 is a correct step.
- Only cycles with code_vld=1 are evaluated; code_vld=0 changes no state, no pulses.
- FSM states HUNT, ACQ, LOCK; run counter 0..LOCK_CNT.
- HUNT: legal → ref=idx, run=0, go ACQ; illegal → illegal pulse, stay.
- ACQ: successor → ref=idx, run+1; run reaching LOCK_CNT → LOCK. Legal non-successor → seq_err, ref=idx, run=0, stay. Illegal → illegal pulse, HUNT.
- LOCK: successor → ref=idx, stay. Legal non-successor → seq_err, ref=idx, run=0, ACQ. Illegal → illegal pulse, HUNT.
- Repeated same code (hold) is a non-successor → seq_err.
- Illegal sample: idx holds, idx_vld=0. Legal sample (incl. seq_err): idx updated, idx_vld=1.
- err_cnt: +1 on each illegal or seq_err pulse, saturates at all-ones. err_clr and error same cycle → err_cnt = 1 (clear then count). err_clr alone → 0.

## Timing
- All outputs registered; response 1 cycle after sampling edge.
- idx, idx_vld, illegal, seq_err, locked reflect the sample of the previous cycle; locked rises on the same edge the FSM enters LOCK.
- Back-to-back code_vld supported every cycle, no stalls.
- Reset (async, any time incl. mid-LOCK): state HUNT, ref=0, run=0, idx=0, idx_vld=0, illegal=0, seq_err=0, locked=0, err_cnt=0. First sample after release handled as HUNT.

## Structure
- Package johnson_pkg: FSM state enum (HUNT, ACQ, LOCK); function for index width ($clog2(2N)).
- Sub-module johnson_idx_decode: combinational code → {legal, idx}, parameter N; reusable by other Johnson consumers.
- Top: FSM, ref/run registers, output registers, saturating counter.

## Test plan
(N=4, LOCK_CNT=3, code_vld=1 every cycle unless stated)
- Reset asserted then released → all outputs 0, locked=0, err_cnt=0.
- Feed 0000,1000,1100,1110 → idx 0,1,2,3 with idx_vld each cycle; locked=1 one cycle after 1110; no pulses.
- In LOCK feed 0011,0001,0000,1000 → idx 6,7,0,1; wrap accepted, locked stays 1, err_cnt unchanged.
- In LOCK feed 1010 → illegal=1, idx_vld=0, idx holds, locked=0 (HUNT), err_cnt=1; then 1100 → idx=2, still unlocked.
- In LOCK at idx 2 feed 1111 (skip) → seq_err=1, idx=4, locked=0; then 0111,0011,0001 → locked=1 after 0001. Hold 0001 twice → seq_err on second.
- ERR_CNT_W=2: five illegal samples → err_cnt=3 (saturated); err_clr with illegal same cycle → err_cnt=1; async rst mid-LOCK → all outputs 0 immediately.
